// File: rtl/cpu_seq_ctrl_if.sv
// cpu_seq_ctrl_if: control bundle between the instruction sequencer and the datapath.
// Datapath side (master) drives run/opcode/zero; the sequencer (slave) drives
// the load enables, mux selects, ALU opcode, memory strobes and debug status.
interface cpu_seq_ctrl_if #(parameter int CNT_W = 16);
    logic             run;
    logic [3:0]       opcode;
    logic             zero;
    logic             pc_en;
    logic             pc_sel;
    logic             ir_en;
    logic             acc_en;
    logic             addr_sel;
    logic             mem_rd;
    logic             mem_we;
    logic [2:0]       alu_op;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output run, opcode, zero,
        input  pc_en, pc_sel, ir_en, acc_en, addr_sel, mem_rd, mem_we,
        input  alu_op, halted, state, instr_cnt
    );

    modport slave (
        input  run, opcode, zero,
        output pc_en, pc_sel, ir_en, acc_en, addr_sel, mem_rd, mem_we,
        output alu_op, halted, state, instr_cnt
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: fetch/decode/execute sequencer for the accumulator CPU.
// Ports: clk (rising-edge clock), clr_n (async active-low reset),
//        bus (slave side of cpu_seq_ctrl_if: run/opcode/zero in; PC/IR/ACC
//        enables, pc_sel, addr_sel, mem_rd/mem_we, alu_op, halted, state,
//        retired-instruction counter instr_cnt out).
module cpu_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         clr_n,
    cpu_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4,
                           OP_JMP = 4'h5, OP_JZ  = 4'h6, OP_AND = 4'h7, OP_OR  = 4'h8,
                           OP_HLT = 4'hF;

    state_t           cur, nxt;
    logic             retire;
    logic [CNT_W-1:0] cnt;
    logic             is_nop, is_mem_alu;

    // NOP plus the undefined codes 9..E finish in DECODE
    assign is_nop     = (bus.opcode == 4'h0) || (bus.opcode >= 4'h9 && bus.opcode <= 4'hE);
    assign is_mem_alu = bus.opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cur <= IDLE;
            cnt <= '0;
        end else begin
            cur <= nxt;
            if (retire) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        nxt          = IDLE;
        retire       = 1'b0;
        bus.pc_en    = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.ir_en    = 1'b0;
        bus.acc_en   = 1'b0;
        bus.addr_sel = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.alu_op   = 3'b000;
        bus.halted   = 1'b0;
        case (cur)
            IDLE: nxt = bus.run ? FETCH : IDLE;
            FETCH: begin
                bus.mem_rd = 1'b1;
                bus.ir_en  = 1'b1;
                nxt        = DECODE;
            end
            DECODE: begin
                bus.pc_en = 1'b1;
                retire    = (bus.opcode == OP_HLT) || is_nop;
                nxt       = (bus.opcode == OP_HLT) ? HALT :
                            is_nop ? (bus.run ? FETCH : IDLE) : EXEC;
            end
            EXEC: begin
                bus.addr_sel = 1'b1;
                bus.mem_rd   = is_mem_alu;
                bus.acc_en   = is_mem_alu;
                bus.alu_op   = (bus.opcode == OP_ADD) ? 3'b001 :
                               (bus.opcode == OP_SUB) ? 3'b010 :
                               (bus.opcode == OP_AND) ? 3'b011 :
                               (bus.opcode == OP_OR)  ? 3'b100 : 3'b000;
                bus.mem_we   = (bus.opcode == OP_STA);
                bus.pc_sel   = (bus.opcode == OP_JMP) || (bus.opcode == OP_JZ);
                bus.pc_en    = (bus.opcode == OP_JMP) || ((bus.opcode == OP_JZ) && bus.zero);
                retire       = 1'b1;
                nxt          = bus.run ? FETCH : IDLE;
            end
            HALT: begin
                bus.halted = 1'b1;
                nxt        = bus.run ? HALT : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign bus.state     = cur;
    assign bus.instr_cnt = cnt;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: self-checking bench for cpu_seq_ctrl (table vectors, directed
// corner sequences, randomized instruction stream against an instruction-level model).
module tb_cpu_seq_ctrl;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic clr4_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;
    int   we_cycles = 0;

    cpu_seq_ctrl_if #(.CNT_W(16)) b ();
    cpu_seq_ctrl_if #(.CNT_W(4))  b4 ();

    cpu_seq_ctrl #(.CNT_W(16)) dut (.clk(clk), .clr_n(clr_n), .bus(b));
    cpu_seq_ctrl #(.CNT_W(4))  u4  (.clk(clk), .clr_n(clr4_n), .bus(b4));

    always #5 clk = ~clk;

    logic [10:0] outs;
    assign outs = {b.pc_en, b.pc_sel, b.ir_en, b.acc_en, b.addr_sel, b.mem_rd,
                   b.mem_we, b.alu_op, b.halted};

    function automatic logic [10:0] mk(bit pe, bit ps, bit ie, bit ae, bit as,
                                       bit mr, bit mw, logic [2:0] alu, bit h);
        return {pe, ps, ie, ae, as, mr, mw, alu, h};
    endfunction

    localparam logic [10:0] F_SIG = 11'h120;  // ir_en, mem_rd
    localparam logic [10:0] D_SIG = 11'h400;  // pc_en
    localparam logic [10:0] H_SIG = 11'h001;  // halted

    // Reference: what the EXEC cycle of each opcode must drive
    function automatic logic [10:0] ref_exec(logic [3:0] op, bit z);
        case (op)
            4'h1: return mk(0, 0, 0, 1, 1, 1, 0, 3'd0, 0);
            4'h3: return mk(0, 0, 0, 1, 1, 1, 0, 3'd1, 0);
            4'h4: return mk(0, 0, 0, 1, 1, 1, 0, 3'd2, 0);
            4'h7: return mk(0, 0, 0, 1, 1, 1, 0, 3'd3, 0);
            4'h8: return mk(0, 0, 0, 1, 1, 1, 0, 3'd4, 0);
            4'h2: return mk(0, 0, 0, 0, 1, 0, 1, 3'd0, 0);
            4'h5: return mk(1, 1, 0, 0, 1, 0, 0, 3'd0, 0);
            4'h6: return mk(z, 1, 0, 0, 1, 0, 0, 3'd0, 0);
            default: return 11'h000;
        endcase
    endfunction

    function automatic bit ref_long(logic [3:0] op);
        return op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; drop lowers run during DECODE
    task automatic do_instr(logic [3:0] op, bit z, bit long_i, logic [10:0] ex, bit drop);
        chk("fetch_state", 32'(b.state), 1);
        chk("fetch_out", 32'(outs), 32'(F_SIG));
        b.opcode = op;
        b.zero   = z;
        step();
        chk("decode_state", 32'(b.state), 2);
        chk("decode_out", 32'(outs), 32'(D_SIG));
        if (drop) b.run = 1'b0;
        if (op == 4'hF) begin
            step();
            exp_cnt++;
            chk("halt_state", 32'(b.state), 4);
            chk("halt_out", 32'(outs), 32'(H_SIG));
            chk("halt_cnt", 32'(b.instr_cnt), exp_cnt & 16'hFFFF);
            return;
        end
        if (long_i) begin
            step();
            chk("exec_state", 32'(b.state), 3);
            chk("exec_out", 32'(outs), 32'(ex));
            if (b.mem_we) we_cycles++;
        end
        step();
        exp_cnt++;
        chk("retire_cnt", 32'(b.instr_cnt), exp_cnt & 16'hFFFF);
        if (drop) begin
            chk("drop_idle", 32'(b.state), 0);
            chk("drop_out", 32'(outs), 0);
            step();
            chk("idle_hold", 32'(b.state), 0);
            b.run = 1'b1;
            step();
        end
    endtask

    task automatic rst_pulse();
        #2 clr_n = 1'b0;
        #2 clr_n = 1'b1;
        exp_cnt = 0;
    endtask

    typedef struct {
        logic [3:0]  op;
        bit          z;
        bit          long_i;
        logic [10:0] ex;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{4'h1, 1'b0, 1'b1, mk(0, 0, 0, 1, 1, 1, 0, 3'd0, 0)};
        tbl[1]  = '{4'h3, 1'b0, 1'b1, mk(0, 0, 0, 1, 1, 1, 0, 3'd1, 0)};
        tbl[2]  = '{4'h4, 1'b0, 1'b1, mk(0, 0, 0, 1, 1, 1, 0, 3'd2, 0)};
        tbl[3]  = '{4'h7, 1'b0, 1'b1, mk(0, 0, 0, 1, 1, 1, 0, 3'd3, 0)};
        tbl[4]  = '{4'h8, 1'b0, 1'b1, mk(0, 0, 0, 1, 1, 1, 0, 3'd4, 0)};
        tbl[5]  = '{4'h2, 1'b0, 1'b1, mk(0, 0, 0, 0, 1, 0, 1, 3'd0, 0)};
        tbl[6]  = '{4'h5, 1'b0, 1'b1, mk(1, 1, 0, 0, 1, 0, 0, 3'd0, 0)};
        tbl[7]  = '{4'h6, 1'b1, 1'b1, mk(1, 1, 0, 0, 1, 0, 0, 3'd0, 0)};
        tbl[8]  = '{4'h6, 1'b0, 1'b1, mk(0, 1, 0, 0, 1, 0, 0, 3'd0, 0)};
        tbl[9]  = '{4'h0, 1'b0, 1'b0, 11'h000};
        tbl[10] = '{4'hB, 1'b0, 1'b0, 11'h000};
        tbl[11] = '{4'h9, 1'b1, 1'b0, 11'h000};
        tbl[12] = '{4'hE, 1'b0, 1'b0, 11'h000};

        b.run = 1'b0; b.opcode = 4'h0; b.zero = 1'b0;
        b4.run = 1'b1; b4.opcode = 4'h0; b4.zero = 1'b0;

        #1;
        chk("rst_state", 32'(b.state), 0);
        chk("rst_cnt", 32'(b.instr_cnt), 0);
        chk("rst_out", 32'(outs), 0);
        #11 clr_n = 1'b1;
        step();
        chk("idle_no_run", 32'(b.state), 0);
        b.run = 1'b1;
        step();

        foreach (tbl[i]) do_instr(tbl[i].op, tbl[i].z, tbl[i].long_i, tbl[i].ex, 1'b0);

        // LDA, ADD, STA, HLT from reset: HALT with count 4 on the 12th edge
        rst_pulse();
        we_cycles = 0;
        step();
        do_instr(4'h1, 1'b0, 1'b1, ref_exec(4'h1, 1'b0), 1'b0);
        do_instr(4'h3, 1'b0, 1'b1, ref_exec(4'h3, 1'b0), 1'b0);
        do_instr(4'h2, 1'b0, 1'b1, ref_exec(4'h2, 1'b0), 1'b0);
        do_instr(4'hF, 1'b0, 1'b0, 11'h000, 1'b0);
        chk("prog_cnt", 32'(b.instr_cnt), 4);
        chk("prog_we_cycles", we_cycles, 1);
        step();
        chk("halt_hold", 32'(b.halted), 1);
        b.run = 1'b0;
        step();
        chk("halt_exit_state", 32'(b.state), 0);
        chk("halt_exit_halted", 32'(b.halted), 0);
        chk("halt_exit_cnt", 32'(b.instr_cnt), 4);
        b.run = 1'b1;
        step();

        // run dropped during DECODE of ADD: instruction still completes
        do_instr(4'h3, 1'b0, 1'b1, ref_exec(4'h3, 1'b0), 1'b1);

        // async reset during EXEC of STA
        b.opcode = 4'h2;
        step();
        step();
        chk("sta_we", 32'(b.mem_we), 1);
        #2 clr_n = 1'b0;
        #1;
        chk("async_we", 32'(b.mem_we), 0);
        chk("async_state", 32'(b.state), 0);
        chk("async_cnt", 32'(b.instr_cnt), 0);
        exp_cnt = 0;
        #1 clr_n = 1'b1;
        step();
        chk("post_rst_fetch", 32'(b.state), 1);

        for (int n = 0; n < 200; n++) begin
            logic [3:0] op;
            bit z, drop;
            op   = 4'($urandom_range(0, 14));
            z    = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 7) == 0);
            do_instr(op, z, ref_long(op), ref_exec(op, z), drop);
        end
        do_instr(4'hF, 1'b0, 1'b0, 11'h000, 1'b0);

        // 4-bit counter wraps after 16 NOPs
        #2 clr4_n = 1'b1;
        step();
        chk("w4_fetch", 32'(b4.state), 1);
        repeat (30) step();
        chk("w4_cnt15", 32'(b4.instr_cnt), 15);
        repeat (2) step();
        chk("w4_wrap", 32'(b4.instr_cnt), 0);
        chk("w4_state", 32'(b4.state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Instruction-cycle sequencer for the accumulator CPU. It sits directly upstream of the `clr`/`en` flip-flop registers (PC, IR, ACC). It steps a fetch/decode/execute state machine and drives their load enables, the mux selects, the ALU opcode and the memory strobes. It also counts retired instructions for debug.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk  input  1  system clock, all state updates on rising edge
- clr_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 = execute program, 0 = stop at next instruction boundary
- opcode  input  4  upper nibble of IR output; valid from DECODE onward
- zero  input  1  accumulator-zero flag (ACC == 0), sampled in EXEC
- pc_en  output  1  load enable for PC registers
- pc_sel  output  1  0 = PC+1, 1 = IR operand (jump target)
- ir_en  output  1  load enable for IR registers
- acc_en  output  1  load enable for ACC registers
- addr_sel  output  1  memory address mux: 0 = PC, 1 = IR operand
- mem_rd  output  1  memory read strobe
- mem_we  output  1  memory write strobe (ACC -> mem[operand])
- alu_op  output  3  000 PASSB, 001 ADD, 010 SUB, 011 AND, 100 OR
- halted  output  1  1 while in HALT
- state  output  3  debug: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4
- instr_cnt  output  CNT_W  retired-instruction count

## Operation
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 JMP, 6 JZ, 7 AND, 8 OR, F HLT. Codes 9–E are treated as NOP.
- IDLE: all strobes 0. Moves to FETCH when run=1.
- FETCH: addr_sel=0, mem_rd=1, ir_en=1. Always moves to DECODE.
- DECODE: pc_en=1, pc_sel=0, so PC increments.
  - HLT -> HALT.
  - NOP/undefined: retire the instruction, then go to FETCH if run=1, else IDLE.
  - All other opcodes -> EXEC.
- EXEC: addr_sel=1, with per-opcode outputs:
  - LDA: mem_rd=1, acc_en=1, alu_op=000.
  - ADD/SUB/AND/OR: mem_rd=1, acc_en=1, alu_op=001/010/011/100.
  - STA: mem_we=1.
  - JMP: pc_en=1, pc_sel=1.
  - JZ: pc_en=zero, pc_sel=1.
  - After any opcode: retire the instruction, then go to FETCH if run=1, else IDLE.
- HALT: halted=1, all strobes 0, HLT is retired on entry. Stays in HALT while run=1. Moves to IDLE when run=0.
- Any output not listed for a state is 0. alu_op is 000 outside EXEC.
- Retire = instr_cnt increments by 1 on that clock edge. It wraps from 2^CNT_W−1 to 0, with no saturation.
- Unreachable state encodings (5–7) return to IDLE on the next edge, with all outputs 0.

## Timing
- clr_n low: state=IDLE, instr_cnt=0 and all outputs 0 immediately, independent of clk. The block leaves reset on the first rising edge after clr_n rises.
- Control outputs are combinational from the current state and opcode/zero (Mealy only in DECODE/EXEC). The downstream registers capture on the same rising edge that advances the state.
- Instruction length:
  - NOP/undefined: 2 cycles (FETCH, DECODE).
  - All others: 3 cycles (FETCH, DECODE, EXEC).
  - HLT: 2 cycles to reach HALT.
- run is sampled only in IDLE, at retire edges and in HALT. Dropping run mid-instruction never aborts it; the current instruction always completes.
- Reset mid-instruction aborts it and the instruction is not counted. mem_we drops asynchronously with clr_n.
- run=1 continuously gives back-to-back instructions with no IDLE gap: EXEC -> FETCH on consecutive edges.
- instr_cnt updates on the edge leaving DECODE (NOP/undefined), the edge leaving EXEC, or the edge entering HALT.

## Test plan
- Reset mid-EXEC of STA: assert clr_n=0 -> mem_we falls to 0 without a clock edge, state=0, instr_cnt=0. After release with run=1, FETCH is asserted on the first edge.
- Program LDA, ADD, STA, HLT with run held 1: states 1,2,3,1,2,3,1,2,3,1,2,4. alu_op is 000 in LDA's EXEC and 001 in ADD's. mem_we is high for exactly 1 cycle. halted=1 and instr_cnt=4 on the 12th edge.
- JZ with zero=1 -> pc_en=1 and pc_sel=1 in EXEC. JZ with zero=0 -> pc_en=0 in EXEC. In both cases pc_en=1 and pc_sel=0 in DECODE.
- run dropped to 0 during DECODE of ADD: EXEC still occurs with acc_en=1, then state goes to IDLE and instr_cnt increments by 1. Re-asserting run resumes at FETCH.
- Opcode B (undefined) and NOP: 2-cycle instructions with no acc_en or mem strobes, each incrementing instr_cnt.
- CNT_W=4, 16 NOPs from reset: instr_cnt wraps to 0. From HALT, dropping run -> IDLE next edge with halted=0.
